// File: rtl/core_pipe_pkg.sv
// Shared pipeline definitions: XLEN and the stage payload bundles
// used to size the data path of the pipeline register stages.
package core_pipe_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd;
  } id_ex_t;

  localparam int IF_ID_W = $bits(if_id_t);
  localparam int ID_EX_W = $bits(id_ex_t);

endpackage

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with optional 2-entry skid buffer
// (registered ready_o) and synchronous flush.
module pipe_skid_stage
  import core_pipe_pkg::*;
#(
  parameter int               DATA_W   = XLEN,
  parameter int               SKID     = 1,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_ro,
  output logic              valid_ro,
  input  logic              ready_i
);

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              cke;

  assign cke = ~valid_q | ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_ro = valid_q;
  assign data_ro  = data_q;

  if (SKID != 0) begin : g_skid
    logic              skid_valid_q;
    logic              skid_valid_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic              accept;

    // ready comes straight from a flop to cut the upstream ready chain
    assign ready_o = ~skid_valid_q;
    assign accept  = valid_i & ~skid_valid_q;

    always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
        valid_d      = 1'b0;
        skid_valid_d = 1'b0;
      end else if (cke) begin
        if (skid_valid_q) begin
          valid_d      = 1'b1;
          data_d       = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          valid_d = 1'b1;
          data_d  = data_i;
        end else begin
          valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = data_i;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        skid_valid_q <= 1'b0;
        skid_data_q  <= RST_DATA;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end
  end else begin : g_bypass
    assign ready_o = cke;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (cke) begin
        valid_d = valid_i;
        if (valid_i) data_d = data_i;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: SKID=0 (u0) and SKID=1 (u1)
// instances, directed vectors plus a random stream per instance.
module tb_pipe_skid_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   vi;
  logic [1:0]   ri;
  logic [1:0]   fl;
  logic [1:0]   ro;
  logic [1:0]   vro;
  logic [W-1:0] di  [2];
  logic [W-1:0] dro [2];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W(W), .SKID(0), .RST_DATA('0)
  ) u0 (
    .clk(clk), .rst(rst), .flush_i(fl[0]),
    .data_i(di[0]), .valid_i(vi[0]), .ready_o(ro[0]),
    .data_ro(dro[0]), .valid_ro(vro[0]), .ready_i(ri[0])
  );

  pipe_skid_stage #(
    .DATA_W(W), .SKID(1), .RST_DATA('0)
  ) u1 (
    .clk(clk), .rst(rst), .flush_i(fl[1]),
    .data_i(di[1]), .valid_i(vi[1]), .ready_o(ro[1]),
    .data_ro(dro[1]), .valid_ro(vro[1]), .ready_i(ri[1])
  );

  function automatic void chk(string nm, int m,
                              logic [W-1:0] act,
                              logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", nm, m, act, exp);
    end
  endfunction

  function automatic void push(int m, logic [W-1:0] d);
    if (m == 0) q0.push_back(d);
    else q1.push_back(d);
  endfunction

  function automatic int qsize(int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [W-1:0] qpop(int m);
    if (m == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void qclr(int m);
    if (m == 0) q0.delete();
    else q1.delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int m, logic [W-1:0] d);
    di[m] = d;
    vi[m] = 1'b1;
  endtask

  // Holds the current input until it is accepted (bounded), recording it.
  task automatic wait_acc(int m);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ro[m] && !fl[m]) begin
        push(m, di[m]);
        done = 1'b1;
      end
      tick();
    end
    vi[m] = 1'b0;
    chk("accept_timeout", m, W'(done), W'(1));
  endtask

  task automatic send(int m, logic [W-1:0] d);
    drive(m, d);
    wait_acc(m);
  endtask

  // Monitor: in-order delivery and output stability under stall
  initial begin
    logic         hold [2];
    logic [W-1:0] hd   [2];
    for (int m = 0; m < 2; m++) begin
      hold[m] = 1'b0;
      hd[m]   = '0;
    end
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          hold[m] = 1'b0;
        end else begin
          if (hold[m]) begin
            chk("hold_valid", m, W'(vro[m]), W'(1));
            chk("hold_data", m, dro[m], hd[m]);
          end
          if (vro[m] && ri[m]) begin
            if (qsize(m) == 0)
              chk("unexpected_out", m, W'(vro[m]), W'(0));
            else
              chk("order", m, dro[m], qpop(m));
          end
          hold[m] = vro[m] && !ri[m] && !fl[m];
          hd[m]   = dro[m];
          if (fl[m]) qclr(m);
        end
      end
    end
  end

  initial begin
    vi = '0;
    ri = '1;
    fl = '0;
    di[0] = '0;
    di[1] = '0;

    #2;
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", m, W'(vro[m]), W'(0));
      chk("rst_ready", m, W'(ro[m]), W'(1));
      chk("rst_data", m, dro[m], W'(0));
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back streaming, 1-cycle latency, no bubbles
    for (int m = 1; m >= 0; m--) begin
      for (int i = 0; i < 8; i++) begin
        send(m, W'(32'h10 + i));
        chk("stream_valid", m, W'(vro[m]), W'(1));
        chk("stream_data", m, dro[m], W'(32'h10 + i));
      end
      repeat (3) tick();
    end

    // Asynchronous reset mid-transfer
    send(1, W'(32'h30));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 1, W'(vro[1]), W'(0));
    chk("arst_ready", 1, W'(ro[1]), W'(1));
    chk("arst_data", 1, dro[1], W'(0));
    qclr(0);
    qclr(1);
    tick();
    rst = 1'b0;
    tick();

    // SKID=1 stall: A held, B to skid, C waits
    send(1, W'(32'hA));
    ri[1] = 1'b0;
    send(1, W'(32'hB));
    chk("stall_data", 1, dro[1], W'(32'hA));
    chk("stall_valid", 1, W'(vro[1]), W'(1));
    chk("stall_ready", 1, W'(ro[1]), W'(0));
    drive(1, W'(32'hC));
    repeat (2) begin
      tick();
      chk("full_ready", 1, W'(ro[1]), W'(0));
      chk("full_data", 1, dro[1], W'(32'hA));
    end
    ri[1] = 1'b1;
    wait_acc(1);
    repeat (4) tick();
    chk("stall_drain", 1, W'(qsize(1)), W'(0));

    // SKID=0 stall: ready_o follows ready_i combinationally
    send(0, W'(32'h21));
    ri[0] = 1'b0;
    #1;
    chk("byp_ready_lo", 0, W'(ro[0]), W'(0));
    repeat (2) begin
      tick();
      chk("byp_hold", 0, dro[0], W'(32'h21));
    end
    ri[0] = 1'b1;
    #1;
    chk("byp_ready_hi", 0, W'(ro[0]), W'(1));
    repeat (3) tick();

    // Flush with main=5, skid=6 and 7 offered
    send(1, W'(32'h5));
    ri[1] = 1'b0;
    send(1, W'(32'h6));
    drive(1, W'(32'h7));
    fl[1] = 1'b1;
    tick();
    fl[1] = 1'b0;
    vi[1] = 1'b0;
    chk("flush_valid", 1, W'(vro[1]), W'(0));
    chk("flush_ready", 1, W'(ro[1]), W'(1));
    ri[1] = 1'b1;
    repeat (4) tick();

    send(0, W'(32'h5));
    ri[0] = 1'b0;
    drive(0, W'(32'h7));
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    vi[0] = 1'b0;
    chk("flush_valid", 0, W'(vro[0]), W'(0));
    chk("flush_ready", 0, W'(ro[0]), W'(1));
    ri[0] = 1'b1;
    repeat (4) tick();

    // Random traffic with rare flushes
    for (int m = 0; m < 2; m++) begin
      repeat (10000) begin
        vi[m] = ($urandom_range(0, 3) != 0);
        di[m] = $urandom;
        ri[m] = ($urandom_range(0, 3) != 0);
        fl[m] = ($urandom_range(0, 63) == 0);
        @(negedge clk);
        if (vi[m] && ro[m] && !fl[m]) push(m, di[m]);
        tick();
      end
      vi[m] = 1'b0;
      fl[m] = 1'b0;
      ri[m] = 1'b1;
      repeat (5) tick();
    end

    chk("final_drain", 0, W'(qsize(0)), W'(0));
    chk("final_drain", 1, W'(qsize(1)), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised valid/ready pipeline register stage carrying a data payload between core pipeline stages (IF/ID/EX/MEM/WB boundaries).
- Adds two things to the plain valid-only stage:
  - a data path of configurable width;
  - an optional 2-entry skid mode that registers ready_o, breaking the combinational ready chain across stages.
- Adds a synchronous flush for branch/exception squash.
- Sustains one transfer per cycle in both modes.

Parameters:
- DATA_W, 32: payload width in bits (XLEN default).
- SKID, 1: 1 = skid mode with registered ready_o; 0 = bypass mode, ready_o = ~valid_ro | ready_i (combinational).
- RST_DATA, 0: reset value of the payload registers.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous squash; drops all held entries.
- data_i  in  DATA_W  upstream payload, sampled on accept.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_ro  out  DATA_W  registered payload to downstream.
- valid_ro  out  1  registered downstream valid.
- ready_i  in  1  downstream ready.

Behaviour:
- Reset is asynchronous and active-high:
  - valid_ro = 0, data_ro = RST_DATA.
  - skid_valid = 0, skid_data = RST_DATA.
  - ready_o = 1 in both modes (in SKID=0, ready_o = ~valid_ro | ready_i = 1).
- Handshake definitions:
  - accept = valid_i & ready_o.
  - issue = valid_ro & ready_i.
  - Latency from accept to valid_ro is 1 cycle; there is no combinational path from data_i to data_ro.
- Output stability:
  - While valid_ro & ~ready_i & ~flush_i, valid_ro and data_ro hold unchanged.
  - data_ro is don't-care when valid_ro = 0, but the registers hold their last value; no spurious loads.
- SKID = 0:
  - cke = ~valid_ro | ready_i.
  - On cke: valid_ro <= valid_i; data_ro <= data_i only when valid_i.
  - On ~cke: hold.
- SKID = 1, with a main register (data_ro/valid_ro) and a skid register (skid_data/skid_valid):
  - ready_o = ~skid_valid, taken directly from a flop.
  - Main empty or issuing (~valid_ro | ready_i):
    - If skid_valid: main <= skid, and skid_valid <= 0.
    - An accept in the same cycle is impossible, because ready_o = 0.
    - Else, if accept: main <= data_i with valid_ro = 1.
    - Else: valid_ro <= 0.
  - Main full and stalled (valid_ro & ~ready_i):
    - If accept: skid <= data_i, skid_valid <= 1; ready_o drops the next cycle.
  - Ordering is strict FIFO: a skid entry always drains before any newer input.
  - Full condition: valid_ro & skid_valid. Nothing more is accepted until the skid entry drains; the stage never overflows.
- flush_i, both modes:
  - Next cycle: valid_ro = 0, skid_valid = 0.
  - An accept coinciding with flush is discarded.
  - An issue coinciding with flush still completes downstream in that cycle.
  - Flush has priority over every other update.
  - Data registers are not cleared.
- Reset asserted mid-transfer clears all valids immediately; in-flight data is lost by design.

Decomposition:
- Shared package core_pipe_pkg holds:
  - XLEN = 32;
  - the common stage payload struct widths used to derive DATA_W at instantiation.
- No sub-module is needed: the skid entry is a single register pair.
- The SKID selection is a generate branch inside this module.

Test Plan:
- Reset: assert rst mid-stream with valid_ro = 1 → valid_ro = 0, ready_o = 1 and data_ro = 0 immediately, without waiting for a clock edge.
- Streaming: valid_i held 1 with data 0x10, 0x11, 0x12…, ready_i = 1 → data_ro shows 0x10 one cycle later, then one word per cycle, no bubbles, in both SKID values.
- Stall, SKID = 1:
  - Stimulus: send 0xA then 0xB; drop ready_i after 0xA reaches the output.
  - Required: data_ro holds 0xA; 0xB goes to skid; ready_o = 0 the next cycle.
  - On raising ready_i: output 0xA, then 0xB, then the next input, in order, none lost or duplicated.
- Stall, SKID = 0: ready_i = 0 with valid_ro = 1 → ready_o = 0 in the same cycle; data_ro is stable until ready_i = 1.
- Flush:
  - Stimulus: main = 0x5, skid = 0x6, new input 0x7 valid; pulse flush_i for one cycle.
  - Required: next cycle valid_ro = 0 and ready_o = 1; 0x5, 0x6 and 0x7 never appear downstream.
- Random: random valid_i/ready_i/rare flush against a scoreboard model → in-order delivery and data_ro stability under stall hold for 10k cycles, in both SKID values.
